mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: AWIDTH, 32, address width; DWIDTH, 32, data width; MASKW, DWIDTH/8, write-byte-mask width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge;
  rst  in  1  synchronous, active-high reset;
  if_req  in  1  fetch request;
  if_addr  in  AWIDTH  fetch address;
  if_gnt  out  1  fetch request latched;
  if_rvalid  out  1  fetch data valid;
  if_rdata  out  DWIDTH  fetch data;
  d_req  in  1  data request from X stage;
  d_we  in  1  1=store, 0=load;
  d_wmask  in  MASKW  store byte mask;
  d_addr  in  AWIDTH  data address;
  d_wdata  in  DWIDTH  store data;
  d_gnt  out  1  data request latched;
  d_rvalid  out  1  load data valid, or store done;
  d_rdata  out  DWIDTH  load data;
  mem_req  out  1  request to shared memory port;
  mem_we  out  1  write enable;
  mem_wmask  out  MASKW  byte mask;
  mem_addr  out  AWIDTH  address;
  mem_wdata  out  DWIDTH  write data;
  mem_ready  in  1  memory accepts mem_req this cycle;
  mem_rvalid  in  1  read data returned;
  mem_rdata  in  DWIDTH  read data;
  stall  out  1  pipeline hold.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-004 In IDLE with any request, the FSM SHALL pick a winner, latch its fields into registers, pulse the winner's gnt for one cycle, and enter ISSUE next cycle.
REQ-005 With if_req and d_req both high in IDLE, the default policy SHALL grant data (d_gnt=1, if_gnt=0).
REQ-006 Requesters SHALL hold req and payload until gnt; the arbiter SHALL ignore payload changes after gnt.
REQ-007 In ISSUE, mem_req SHALL be 1 and mem_we/mem_wmask/mem_addr/mem_wdata SHALL come from the latched registers; mem_req SHALL stay high until the cycle mem_ready=1.
REQ-008 On acceptance of a read, the FSM SHALL go ISSUE->WAIT.
REQ-009 On acceptance of a write, the FSM SHALL go ISSUE->IDLE and pulse d_rvalid in the acceptance cycle; d_rdata is don't-care then.
REQ-010 In WAIT with mem_rvalid=1, the FSM SHALL pulse the owner's rvalid, pass mem_rdata combinationally to that owner's rdata, and return to IDLE; minimum read latency is req->gnt (cycle 0) -> mem_req (1) -> rvalid (2 at earliest).
REQ-011 mem_rvalid outside WAIT SHALL be ignored: no rvalid pulse, no state change.
REQ-012 stall SHALL be 1 whenever a request is raised or in flight and its rvalid has not yet pulsed; it SHALL be 0 in the completing cycle and in IDLE with no requests.
REQ-013 New arbitration SHALL occur only in IDLE; a request arriving in ISSUE or WAIT waits, and back-to-back service costs one IDLE cycle between transactions.
REQ-014 if_rdata and d_rdata SHALL be 0 when the matching rvalid is 0.

Reset
REQ-015 While rst=1 at a clock edge: state=IDLE; all outputs SHALL be 0, including gnt, rvalid, mem_req and stall; latched registers SHALL be 0; the round-robin pointer SHALL point to fetch.
REQ-016 Reset mid-transaction SHALL abandon it; a later mem_rvalid for it SHALL be ignored per REQ-011.

Configuration
REQ-017 With macro MEM_ARB_RR_EN defined, ties SHALL go to the requester not granted last; last_grant updates on every gnt, and after reset the first tie goes to data.
REQ-018 Without MEM_ARB_RR_EN, fixed data priority (REQ-005) SHALL apply and no pointer register SHALL exist.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (2 bits), the owner encoding (FETCH=0, DATA=1), and the AWIDTH/DWIDTH defaults.
REQ-020 Winner selection SHALL be one sub-module, mem_arb_picker (inputs: two reqs and last_grant; outputs: one-hot grant), with the macro applied inside it.

Verification
REQ-021 Fetch only: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid one cycle later with 0xDEADBEEF -> if_gnt at cycle 0, mem_req at cycle 1, if_rvalid and if_rdata=0xDEADBEEF at cycle 2, stall low at cycle 2.
REQ-022 Tie, no macro: both reqs high for 3 transactions -> all grants go to data, and fetch is granted only after d_req drops.
REQ-023 Tie, MEM_ARB_RR_EN: both reqs held high -> grants alternate D, F, D, F starting with data after reset.
REQ-024 Store with backpressure: d_we=1, d_wmask=0xF, mem_ready low for 3 cycles -> mem_req and payload held stable for 4 cycles, d_rvalid pulses in the acceptance cycle, and no WAIT state.
REQ-025 rst pulsed while in WAIT, then mem_rvalid=1 -> no rvalid pulse, and all outputs are 0 during reset.
REQ-026 Spurious mem_rvalid in IDLE -> no rvalid pulse and state unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, owner ids, width defaults.
package mem_arbiter_pkg;

   localparam int AWIDTH_DEF = 32;
   localparam int DWIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_picker.sv
// Winner selection between fetch and data requests; grant is one-hot {data, fetch}.
// Define MEM_ARB_RR_EN to resolve ties toward the requester not granted last.
module mem_arb_picker
   import mem_arbiter_pkg::*;
(
   input  logic       if_req,
   input  logic       d_req,
   input  owner_t     last_grant,
   output logic [1:0] grant
);

   logic tie_to_data;

`ifdef MEM_ARB_RR_EN
   assign tie_to_data = (last_grant == OWN_FETCH);
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign tie_to_data       = 1'b1;
`endif

   always_comb begin
      grant = 2'b00;
      if (d_req && (!if_req || tie_to_data))
         grant[1] = 1'b1;
      else if (if_req)
         grant[0] = 1'b1;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory port, one transaction in flight.
// Optional MEM_ARB_RR_EN: round-robin tie breaking instead of fixed data priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int MASKW  = DWIDTH / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [AWIDTH-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DWIDTH-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [MASKW-1:0]  d_wmask,
   input  logic [AWIDTH-1:0] d_addr,
   input  logic [DWIDTH-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DWIDTH-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MASKW-1:0]  mem_wmask,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              stall
);

   arb_state_t        state;
   owner_t            owner_q;
   logic              we_q;
   logic [MASKW-1:0]  wmask_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;
   logic [1:0]        pick;
   owner_t            last_grant;

   logic arb_idle, issue, wr_done, rd_done;
   assign arb_idle = (state == ST_IDLE);
   assign issue    = (state == ST_ISSUE);
   assign wr_done  = issue && mem_ready && we_q;
   assign rd_done  = (state == ST_WAIT) && mem_rvalid;

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= OWN_FETCH;
      else if (arb_idle && (|pick))
         last_grant <= pick[1] ? OWN_DATA : OWN_FETCH;
   end
`else
   assign last_grant = OWN_DATA;
`endif

   mem_arb_picker u_picker (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant      (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner_q <= OWN_FETCH;
         we_q    <= 1'b0;
         wmask_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|pick) begin
               state <= ST_ISSUE;
               if (pick[1]) begin
                  owner_q <= OWN_DATA;
                  we_q    <= d_we;
                  wmask_q <= d_wmask;
                  addr_q  <= d_addr;
                  wdata_q <= d_wdata;
               end else begin
                  owner_q <= OWN_FETCH;
                  we_q    <= 1'b0;
                  wmask_q <= '0;
                  addr_q  <= if_addr;
                  wdata_q <= '0;
               end
            end
            ST_ISSUE: if (mem_ready) state <= we_q ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (mem_rvalid) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Every output is forced low while rst is asserted, even before the reset edge lands.
   assign if_gnt    = !rst && arb_idle && pick[0];
   assign d_gnt     = !rst && arb_idle && pick[1];
   assign if_rvalid = !rst && rd_done && (owner_q == OWN_FETCH);
   assign d_rvalid  = !rst && (wr_done || (rd_done && (owner_q == OWN_DATA)));
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid && !wr_done) ? mem_rdata : '0;

   assign mem_req   = !rst && issue;
   assign mem_we    = mem_req && we_q;
   assign mem_wmask = mem_req ? wmask_q : '0;
   assign mem_addr  = mem_req ? addr_q  : '0;
   assign mem_wdata = mem_req ? wdata_q : '0;

   assign stall = !rst && (arb_idle ? (if_req || d_req) : !(wr_done || rd_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus randomized traffic, both checked against a transaction-level model.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_req, d_req, d_we, mem_ready, mem_rvalid;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_wmask;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, stall;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;

   mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MASKW(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall(stall)
   );

   typedef struct {
      bit rst, ifr; logic [31:0] ia;
      bit dr, dwe; logic [3:0] dm; logic [31:0] da, dd;
      bit mr, mrv; logic [31:0] mrd;
      bit [1:0] eg, erv; bit emq, est; logic [31:0] ema, erd;
   } vec_t;

   vec_t tbl[25];
   int   total = 0, bad = 0;

   // Model: one pending transaction record, plus who won the last grant.
   bit          m_valid = 0, m_acc = 0, m_owner_d = 0, m_we = 0, m_last_data = 0;
   logic [3:0]  m_mask = '0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   bit          g_if, g_d;

   function automatic vec_t mk(bit r, bit ifr, logic [31:0] ia, bit dr, bit dwe, logic [3:0] dm,
                               logic [31:0] da, logic [31:0] dd, bit mr, bit mrv, logic [31:0] mrd,
                               bit [1:0] eg, bit [1:0] erv, bit emq, bit est,
                               logic [31:0] ema, logic [31:0] erd);
      vec_t v;
      v.rst = r; v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dm = dm; v.da = da; v.dd = dd;
      v.mr = mr; v.mrv = mrv; v.mrd = mrd; v.eg = eg; v.erv = erv; v.emq = emq; v.est = est;
      v.ema = ema; v.erd = erd;
      return v;
   endfunction

   task automatic model_eval(output logic [138:0] v, output bit wr_cmp);
      bit idle, mq, rd, rv_if, rv_d, st;
      idle = !m_valid;
      g_if = 0; g_d = 0;
      if (idle && if_req && d_req) begin
         if (RR && m_last_data) g_if = 1; else g_d = 1;
      end else if (idle) begin
         g_if = if_req; g_d = d_req;
      end
      mq     = m_valid && !m_acc;
      wr_cmp = mq && mem_ready && m_we;
      rd     = m_valid && m_acc && mem_rvalid;
      rv_d   = wr_cmp || (rd && m_owner_d);
      rv_if  = rd && !m_owner_d;
      st     = idle ? (if_req || d_req) : !(wr_cmp || rd);
      v = {g_if, rv_if, rv_if ? mem_rdata : 32'h0, g_d, rv_d, (rd && m_owner_d) ? mem_rdata : 32'h0,
           mq, mq && m_we, mq ? m_mask : 4'h0, mq ? m_addr : 32'h0, mq ? m_wdata : 32'h0, st};
      if (rst) begin
         v = '0; g_if = 0; g_d = 0; wr_cmp = 0;
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_valid = 0; m_acc = 0; m_last_data = 0;
      end else if (!m_valid) begin
         if (g_d) begin
            m_valid = 1; m_acc = 0; m_owner_d = 1; m_we = d_we; m_mask = d_wmask;
            m_addr = d_addr; m_wdata = d_wdata; m_last_data = 1;
         end else if (g_if) begin
            m_valid = 1; m_acc = 0; m_owner_d = 0; m_we = 0; m_mask = '0;
            m_addr = if_addr; m_wdata = '0; m_last_data = 0;
         end
      end else if (!m_acc) begin
         if (mem_ready) begin
            if (m_we) m_valid = 0; else m_acc = 1;
         end
      end else if (mem_rvalid) begin
         m_valid = 0;
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked mid-cycle.
   task automatic cyc(input string nm, input int idx, input bit use_row, input vec_t r);
      logic [138:0] e, a;
      logic [71:0]  tv, te;
      bit           wc;
      #4;
      model_eval(e, wc);
      a = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, wc ? 32'h0 : d_rdata,
           mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, stall};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s%0d model got=%h want=%h", nm, idx, a, e);
      end
      if (use_row) begin
         tv = {d_gnt, if_gnt, d_rvalid, if_rvalid, mem_req, stall, mem_addr,
               if_rdata | (wc ? 32'h0 : d_rdata)};
         te = {r.eg, r.erv, r.emq, r.est, r.ema, r.erd};
         total++;
         if (tv !== te) begin
            bad++;
            $display("FAIL %s%0d table got=%h want=%h", nm, idx, tv, te);
         end
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      vec_t dummy;
      bit   ip, dp;
      tbl[0]  = mk(1,1,'h100,0,0,0,0,0,0,0,0,          2'b00,2'b00,0,0,0,0);
      tbl[1]  = mk(0,1,'h100,0,0,0,0,0,1,0,0,          2'b01,2'b00,0,1,0,0);
      tbl[2]  = mk(0,0,'h100,0,0,0,0,0,1,0,0,          2'b00,2'b00,1,1,'h100,0);
      tbl[3]  = mk(0,0,0,0,0,0,0,0,0,1,'hDEADBEEF,     2'b00,2'b01,0,0,0,'hDEADBEEF);
      tbl[4]  = mk(0,0,0,0,0,0,0,0,0,1,'h1111,         2'b00,2'b00,0,0,0,0);
      tbl[5]  = mk(0,0,0,1,1,'hF,'h20,'h1234,0,0,0,    2'b10,2'b00,0,1,0,0);
      tbl[6]  = mk(0,0,0,0,0,0,'hFFF0,'h9999,0,0,0,    2'b00,2'b00,1,1,'h20,0);
      tbl[7]  = tbl[6];
      tbl[8]  = tbl[6];
      tbl[9]  = mk(0,0,0,0,0,0,'hFFF0,'h9999,1,0,0,    2'b00,2'b10,1,0,'h20,0);
      tbl[10] = mk(0,0,0,0,0,0,0,0,0,1,'h2222,         2'b00,2'b00,0,0,0,0);
      tbl[11] = mk(1,0,0,0,0,0,0,0,0,0,0,              2'b00,2'b00,0,0,0,0);
      tbl[12] = mk(0,1,'h200,1,0,0,'h40,0,0,0,0,       2'b10,2'b00,0,1,0,0);
      tbl[13] = mk(0,1,'h200,1,0,0,'h40,0,1,0,0,       2'b00,2'b00,1,1,'h40,0);
      tbl[14] = mk(0,1,'h200,1,0,0,'h40,0,0,1,'hAAAA,  2'b00,2'b10,0,0,0,'hAAAA);
      tbl[15] = mk(0,1,'h200,1,0,0,'h40,0,0,0,0,       RR ? 2'b01 : 2'b10,2'b00,0,1,0,0);
      tbl[16] = mk(0,1,'h200,1,0,0,'h40,0,1,0,0,       2'b00,2'b00,1,1,RR ? 32'h200 : 32'h40,0);
      tbl[17] = mk(0,1,'h200,1,0,0,'h40,0,0,1,'hBBBB,  2'b00,RR ? 2'b01 : 2'b10,0,0,0,'hBBBB);
      tbl[18] = mk(0,1,'h200,1,0,0,'h40,0,0,0,0,       2'b10,2'b00,0,1,0,0);
      tbl[19] = mk(0,1,'h200,1,0,0,'h40,0,1,0,0,       2'b00,2'b00,1,1,'h40,0);
      tbl[20] = mk(0,1,'h200,1,0,0,'h40,0,0,1,'hCCCC,  2'b00,2'b10,0,0,0,'hCCCC);
      tbl[21] = mk(0,1,'h300,0,0,0,0,0,0,0,0,          2'b01,2'b00,0,1,0,0);
      tbl[22] = mk(0,0,'h300,0,0,0,0,0,1,0,0,          2'b00,2'b00,1,1,'h300,0);
      tbl[23] = mk(1,1,'h300,0,0,0,0,0,0,0,0,          2'b00,2'b00,0,0,0,0);
      tbl[24] = mk(0,0,0,0,0,0,0,0,0,1,'hEEEE,         2'b00,2'b00,0,0,0,0);

      rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_wmask = '0; d_addr = '0;
      d_wdata = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 25; i++) begin
         rst = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ia;
         d_req = tbl[i].dr; d_we = tbl[i].dwe; d_wmask = tbl[i].dm; d_addr = tbl[i].da;
         d_wdata = tbl[i].dd; mem_ready = tbl[i].mr; mem_rvalid = tbl[i].mrv; mem_rdata = tbl[i].mrd;
         cyc("row", i, 1'b1, tbl[i]);
      end

      // Random traffic: requesters hold request and payload until granted.
      dummy = tbl[0];
      ip = 0; dp = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; if_addr = $urandom;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; d_we = 1'($urandom_range(0, 1)); d_wmask = 4'($urandom_range(0, 15));
            d_addr = $urandom; d_wdata = $urandom;
         end
         if_req = ip; d_req = dp;
         mem_ready  = 1'($urandom_range(0, 1));
         mem_rvalid = ($urandom_range(0, 2) == 0);
         mem_rdata  = $urandom;
         cyc("rnd", n, 1'b0, dummy);
         if (g_if) ip = 0;
         if (g_d)  dp = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
